// File: rtl/divider_stim_sequencer.sv
// Stimulus/check engine for the sequential divider: generates operand pairs, drives start,
// waits for done, verifies Q*B+R==A with R<B, and keeps vector/error/timeout counts.
module divider_stim_sequencer #(
  parameter int unsigned     WIDTH     = 24,
  parameter int unsigned     NUM_VEC   = 16,
  parameter int unsigned     START_CYC = 1,
  parameter int unsigned     TIMEOUT   = 64,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'('h000001),
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'('hE10000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             finished,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SC_W  = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int unsigned TM_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt;
  logic [WIDTH-1:0] q_cap, q_nxt, r_cap, r_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic [SC_W-1:0]  sc_cnt, sc_nxt;
  logic [TM_W-1:0]  timer, timer_nxt;
  logic             start_nxt, busy_nxt, fin_nxt, to_nxt;
  logic [CNT_W-1:0] vec_nxt, err_nxt, err_inc, vec_inc;

  logic [WIDTH-1:0] step1, step2, load_a, load_b;
  logic [PW-1:0]    prod;
  logic             fail;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Operand generation for the current vector; mode 3 falls back to fixed operands.
  always_comb begin
    step1  = lfsr_step(lfsr);
    step2  = lfsr_step(step1);
    load_a = cfg_a;
    load_b = cfg_b;
    case (mode)
      2'd1: begin
        load_a = cfg_a + WIDTH'(vec_count);
        load_b = cfg_b + WIDTH'(vec_count);
      end
      2'd2: begin
        load_a = step1;
        load_b = step2 >> (WIDTH / 2);
      end
      default: ;
    endcase
    if (load_b == '0) load_b = WIDTH'(1);
  end

  assign prod    = PW'(q_cap) * PW'(B) + PW'(r_cap);
  assign fail    = (prod != PW'(A)) || (r_cap >= B);
  assign err_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  assign vec_inc = vec_count + 16'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    b_nxt     = B;
    start_nxt = start;
    busy_nxt  = busy;
    fin_nxt   = finished;
    vec_nxt   = vec_count;
    err_nxt   = err_count;
    to_nxt    = timeout_err;
    lfsr_nxt  = lfsr;
    q_nxt     = q_cap;
    r_nxt     = r_cap;
    sc_nxt    = sc_cnt;
    timer_nxt = timer;
    case (state)
      S_IDLE, S_DONE: begin
        if (run) begin
          vec_nxt   = '0;
          err_nxt   = '0;
          to_nxt    = 1'b0;
          fin_nxt   = 1'b0;
          lfsr_nxt  = SEED;
          busy_nxt  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        a_nxt     = load_a;
        b_nxt     = load_b;
        if (mode == 2'd2) lfsr_nxt = step2;
        start_nxt = 1'b1;
        sc_nxt    = '0;
        state_nxt = S_START;
      end
      S_START: begin
        if (sc_cnt == SC_W'(START_CYC - 1)) begin
          start_nxt = 1'b0;
          timer_nxt = '0;
          state_nxt = S_WAIT;
        end else begin
          sc_nxt = sc_cnt + SC_W'(1);
        end
      end
      S_WAIT: begin
        if (done) begin
          q_nxt     = Q;
          r_nxt     = R;
          state_nxt = S_CHECK;
        end else if (timer == TM_W'(TIMEOUT - 1)) begin
          to_nxt    = 1'b1;
          err_nxt   = err_inc;
          state_nxt = S_NEXT;
        end else begin
          timer_nxt = timer + TM_W'(1);
        end
      end
      S_CHECK: begin
        if (fail) err_nxt = err_inc;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        vec_nxt = vec_inc;
        if (vec_inc == CNT_W'(NUM_VEC)) begin
          busy_nxt  = 1'b0;
          fin_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      A           <= '0;
      B           <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      vec_count   <= '0;
      err_count   <= '0;
      timeout_err <= 1'b0;
      lfsr        <= SEED;
      q_cap       <= '0;
      r_cap       <= '0;
      sc_cnt      <= '0;
      timer       <= '0;
    end else begin
      state       <= state_nxt;
      A           <= a_nxt;
      B           <= b_nxt;
      start       <= start_nxt;
      busy        <= busy_nxt;
      finished    <= fin_nxt;
      vec_count   <= vec_nxt;
      err_count   <= err_nxt;
      timeout_err <= to_nxt;
      lfsr        <= lfsr_nxt;
      q_cap       <= q_nxt;
      r_cap       <= r_nxt;
      sc_cnt      <= sc_nxt;
      timer       <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_divider_stim_sequencer.sv
// Directed bench for divider_stim_sequencer: a one-vector instance and a two-vector instance
// (START_CYC=2), each answered by a behavioural divider model that can lie or hang.
module tb_divider_stim_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] cfg_a = '0, cfg_b = '0;
  logic        run1 = 1'b0, run2 = 1'b0;

  logic [23:0] a1, b1, q1 = '0, r1 = '0;
  logic        start1, done1 = 1'b0, busy1, fin1, to1;
  logic [15:0] vc1, ec1;
  logic [23:0] a2, b2, q2 = '0, r2 = '0;
  logic        start2, done2 = 1'b0, busy2, fin2, to2;
  logic [15:0] vc2, ec2;

  // Divider model controls
  logic        hang = 1'b0, ovr = 1'b0;
  logic [23:0] ovr_q = '0, ovr_r = '0;
  logic [2:0]  cnt1 = '0, cnt2 = '0;
  logic        sprev1 = 1'b0, sprev2 = 1'b0;

  // Capture of dut2 operands at each start rising edge, plus start pulse width
  logic [23:0] cap_a[$], cap_b[$];
  logic        mprev = 1'b0;
  int          cur_w = 0, last_w = 0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  divider_stim_sequencer #(.WIDTH(24), .NUM_VEC(1), .START_CYC(1), .TIMEOUT(64)) u_one (
    .clk(clk), .reset(reset), .run(run1), .mode(mode), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .A(a1), .B(b1), .start(start1), .done(done1), .Q(q1), .R(r1), .busy(busy1),
    .finished(fin1), .vec_count(vc1), .err_count(ec1), .timeout_err(to1));

  divider_stim_sequencer #(.WIDTH(24), .NUM_VEC(2), .START_CYC(2), .TIMEOUT(64)) u_two (
    .clk(clk), .reset(reset), .run(run2), .mode(mode), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .A(a2), .B(b2), .start(start2), .done(done2), .Q(q2), .R(r2), .busy(busy2),
    .finished(fin2), .vec_count(vc2), .err_count(ec2), .timeout_err(to2));

  // Divider model: answers three cycles after a start rising edge unless hanging
  always @(posedge clk) begin
    done1 <= 1'b0;
    done2 <= 1'b0;
    sprev1 <= start1;
    sprev2 <= start2;
    if (reset) cnt1 <= '0;
    else if (start1 && !sprev1) cnt1 <= 3'd3;
    else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 3'd1;
      if (cnt1 == 3'd1 && !hang) begin
        done1 <= 1'b1;
        q1 <= ovr ? ovr_q : ((b1 == 0) ? 24'd0 : a1 / b1);
        r1 <= ovr ? ovr_r : ((b1 == 0) ? 24'd0 : a1 % b1);
      end
    end
    if (reset) cnt2 <= '0;
    else if (start2 && !sprev2) cnt2 <= 3'd3;
    else if (cnt2 != 0) begin
      cnt2 <= cnt2 - 3'd1;
      if (cnt2 == 3'd1 && !hang) begin
        done2 <= 1'b1;
        q2 <= ovr ? ovr_q : ((b2 == 0) ? 24'd0 : a2 / b2);
        r2 <= ovr ? ovr_r : ((b2 == 0) ? 24'd0 : a2 % b2);
      end
    end
  end

  always @(negedge clk) begin
    if (start2 && !mprev) begin
      cap_a.push_back(a2);
      cap_b.push_back(b2);
      cur_w = 1;
    end else if (start2) begin
      cur_w = cur_w + 1;
    end
    if (!start2 && mprev) last_w = cur_w;
    mprev = start2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic pulse_run(input int which);
    @(negedge clk);
    if (which == 1) run1 = 1'b1; else run2 = 1'b1;
    @(negedge clk);
    run1 = 1'b0;
    run2 = 1'b0;
  endtask

  task automatic wait_fin(input int which, input string tag, input int budget);
    int n = 0;
    while (((which == 1) ? fin1 : fin2) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((which == 1) ? fin1 : fin2) !== 1'b1) begin
      errors++;
      $display("FAIL %s_finish_wait finished=0 after %0d cycles, required 1", tag, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a1, b1, start1, busy1, fin1, vc1, ec1, to1} !== 84'd0) begin
      errors++;
      $display("FAIL reset_one A=%h B=%h st=%b busy=%b fin=%b vc=%0d ec=%0d to=%b, required all 0",
               a1, b1, start1, busy1, fin1, vc1, ec1, to1);
    end
    checks++;
    if ({a2, b2, start2, busy2, fin2, vc2, ec2, to2} !== 84'd0) begin
      errors++;
      $display("FAIL reset_two A=%h B=%h st=%b busy=%b fin=%b vc=%0d ec=%0d to=%b, required all 0",
               a2, b2, start2, busy2, fin2, vc2, ec2, to2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    mode = 2'd0; cfg_a = 24'h2625A0; cfg_b = 24'h001068;
    ovr = 1'b1; ovr_q = 24'h000253; ovr_r = 24'h0003E8;
    pulse_run(1);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL fixed_busy got=%b required=1", busy1);
    end
    wait_fin(1, "fixed", 100);
    checks++;
    if ({fin1, busy1, vc1, ec1, to1} !== {1'b1, 1'b0, 16'd1, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL fixed_status fin=%b busy=%b vc=%0d ec=%0d to=%b, required 1 0 1 0 0",
               fin1, busy1, vc1, ec1, to1);
    end
    checks++;
    if ({a1, b1} !== {24'h2625A0, 24'h001068}) begin
      errors++; $display("FAIL fixed_operands A=%h B=%h required A=2625a0 B=001068", a1, b1);
    end
  endtask

  task automatic test_check_fail();
    logic [23:0] qs[3] = '{24'h253, 24'h253, 24'h252};
    logic [23:0] rs[3] = '{24'h3E9, 24'h1068, 24'h1450};
    for (int i = 0; i < 3; i++) begin
      ovr = 1'b1; ovr_q = qs[i]; ovr_r = rs[i];
      pulse_run(1);
      wait_fin(1, "checkfail", 100);
      checks++;
      if ({ec1, vc1, to1} !== {16'd1, 16'd1, 1'b0}) begin
        errors++;
        $display("FAIL checkfail_%0d ec=%0d vc=%0d to=%b, required ec=1 vc=1 to=0", i, ec1, vc1, to1);
      end
    end
  endtask

  task automatic test_reserved_zero_b();
    mode = 2'd3; cfg_a = 24'h123456; cfg_b = 24'h0;
    ovr = 1'b0;
    pulse_run(1);
    wait_fin(1, "reserved", 100);
    checks++;
    if ({a1, b1} !== {24'h123456, 24'h000001}) begin
      errors++; $display("FAIL reserved_operands A=%h B=%h required A=123456 B=000001", a1, b1);
    end
    checks++;
    if ({ec1, vc1} !== {16'd0, 16'd1}) begin
      errors++; $display("FAIL reserved_status ec=%0d vc=%0d required ec=0 vc=1", ec1, vc1);
    end
  endtask

  task automatic test_ramp_wrap();
    int n0 = cap_a.size();
    mode = 2'd1; cfg_a = 24'd10; cfg_b = 24'hFFFFFF; ovr = 1'b0;
    pulse_run(2);
    wait_fin(2, "ramp", 200);
    checks++;
    if (cap_a.size() != n0 + 2) begin
      errors++; $display("FAIL ramp_vectors got=%0d required=2", cap_a.size() - n0);
    end else begin
      checks++;
      if ({cap_a[n0], cap_b[n0]} !== {24'd10, 24'hFFFFFF}) begin
        errors++; $display("FAIL ramp_vec0 A=%h B=%h required A=00000a B=ffffff", cap_a[n0], cap_b[n0]);
      end
      checks++;
      if ({cap_a[n0+1], cap_b[n0+1]} !== {24'd11, 24'd1}) begin
        errors++;
        $display("FAIL ramp_vec1 A=%h B=%h required A=00000b B=000001", cap_a[n0+1], cap_b[n0+1]);
      end
    end
    checks++;
    if (last_w != 2) begin
      errors++; $display("FAIL ramp_start_width got=%0d required=2", last_w);
    end
    checks++;
    if ({vc2, ec2, to2, busy2} !== {16'd2, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ramp_status vc=%0d ec=%0d to=%b busy=%b required 2 0 0 0", vc2, ec2, to2, busy2);
    end
  endtask

  task automatic test_timeout();
    mode = 2'd0; cfg_a = 24'd100; cfg_b = 24'd7; ovr = 1'b0; hang = 1'b1;
    pulse_run(2);
    wait_fin(2, "timeout", 400);
    checks++;
    if ({to2, ec2, vc2, busy2} !== {1'b1, 16'd2, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_status to=%b ec=%0d vc=%0d busy=%b required 1 2 2 0", to2, ec2, vc2, busy2);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 2'd1; cfg_a = 24'd50; cfg_b = 24'd5;
    ovr = 1'b1; ovr_q = 24'd0; ovr_r = 24'd0;
    pulse_run(2);
    n = 0;
    while (vc2 !== 16'd1 && n < 200) begin @(negedge clk); n++; end
    hang = 1'b1;
    n = 0;
    while (start2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (start2 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy2, vc2, ec2} !== {1'b1, 16'd1, 16'd1}) begin
      errors++; $display("FAIL midreset_before busy=%b vc=%0d ec=%0d required 1 1 1", busy2, vc2, ec2);
    end
    reset = 1'b1; run2 = 1'b1;
    @(negedge clk);
    checks++;
    if ({a2, b2, start2, busy2, fin2, vc2, ec2, to2} !== 84'd0) begin
      errors++;
      $display("FAIL midreset_after A=%h B=%h st=%b busy=%b fin=%b vc=%0d ec=%0d to=%b, required all 0",
               a2, b2, start2, busy2, fin2, vc2, ec2, to2);
    end
    reset = 1'b0; run2 = 1'b0;
    hang = 1'b0; ovr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL midreset_run_lost busy=%b required 0", busy2);
    end
    pulse_run(2);
    wait_fin(2, "midreset_rerun", 200);
    checks++;
    if ({vc2, ec2, to2} !== {16'd2, 16'd0, 1'b0}) begin
      errors++; $display("FAIL midreset_rerun vc=%0d ec=%0d to=%b required 2 0 0", vc2, ec2, to2);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_a[2] = '{24'hE10000, 24'h384000};
    logic [23:0] exp_b[2] = '{24'h000708, 24'h0001C2};
    int n0 = cap_a.size();
    mode = 2'd2; ovr = 1'b0; hang = 1'b0;
    pulse_run(2);
    repeat (3) @(negedge clk);
    pulse_run(2);
    wait_fin(2, "lfsr_run1", 200);
    checks++;
    if ({vc2, ec2, cap_a.size() == n0 + 2} !== {16'd2, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL lfsr_run1_status vc=%0d ec=%0d vectors=%0d required 2 0 2", vc2, ec2, cap_a.size() - n0);
    end
    pulse_run(2);
    wait_fin(2, "lfsr_run2", 200);
    checks++;
    if ({vc2, ec2} !== {16'd2, 16'd0}) begin
      errors++; $display("FAIL lfsr_run2_status vc=%0d ec=%0d required 2 0", vc2, ec2);
    end
    checks++;
    if (cap_a.size() != n0 + 4) begin
      errors++; $display("FAIL lfsr_vectors got=%0d required=4", cap_a.size() - n0);
    end else begin
      for (int r = 0; r < 2; r++) begin
        for (int v = 0; v < 2; v++) begin
          checks++;
          if ({cap_a[n0+2*r+v], cap_b[n0+2*r+v]} !== {exp_a[v], exp_b[v]}) begin
            errors++;
            $display("FAIL lfsr_run%0d_vec%0d A=%h B=%h required A=%h B=%h", r, v,
                     cap_a[n0+2*r+v], cap_b[n0+2*r+v], exp_a[v], exp_b[v]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_check_fail();
    test_reserved_zero_b();
    test_ramp_wrap();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
